// File: rtl/vip_axi4_wr_arbiter.sv
// N-to-1 AXI4 write-channel arbiter: round-robin over AW requests, with one
// transaction (AW, W burst, B) in flight at a time and a W burst length check.
module vip_axi4_wr_arbiter #(
    parameter int NR_OF_PORTS_P = 4,
    parameter int ID_WIDTH_P    = 4,
    parameter int ADDR_WIDTH_P  = 32,
    parameter int DATA_WIDTH_P  = 64
) (
    input  logic                                     clk,
    input  logic                                     rst,
    // requester AW
    input  logic [NR_OF_PORTS_P*ID_WIDTH_P-1:0]      req_awid,
    input  logic [NR_OF_PORTS_P*ADDR_WIDTH_P-1:0]    req_awaddr,
    input  logic [NR_OF_PORTS_P*8-1:0]               req_awlen,
    input  logic [NR_OF_PORTS_P*3-1:0]               req_awsize,
    input  logic [NR_OF_PORTS_P*2-1:0]               req_awburst,
    input  logic [NR_OF_PORTS_P-1:0]                 req_awvalid,
    output logic [NR_OF_PORTS_P-1:0]                 req_awready,
    // requester W
    input  logic [NR_OF_PORTS_P*DATA_WIDTH_P-1:0]    req_wdata,
    input  logic [NR_OF_PORTS_P*DATA_WIDTH_P/8-1:0]  req_wstrb,
    input  logic [NR_OF_PORTS_P-1:0]                 req_wlast,
    input  logic [NR_OF_PORTS_P-1:0]                 req_wvalid,
    output logic [NR_OF_PORTS_P-1:0]                 req_wready,
    // requester B
    output logic [NR_OF_PORTS_P*ID_WIDTH_P-1:0]      req_bid,
    output logic [NR_OF_PORTS_P*2-1:0]               req_bresp,
    output logic [NR_OF_PORTS_P-1:0]                 req_bvalid,
    input  logic [NR_OF_PORTS_P-1:0]                 req_bready,
    // master
    output logic [ID_WIDTH_P-1:0]                    awid,
    output logic [ADDR_WIDTH_P-1:0]                  awaddr,
    output logic [7:0]                               awlen,
    output logic [2:0]                               awsize,
    output logic [1:0]                               awburst,
    output logic                                     awvalid,
    input  logic                                     awready,
    output logic [DATA_WIDTH_P-1:0]                  wdata,
    output logic [DATA_WIDTH_P/8-1:0]                wstrb,
    output logic                                     wlast,
    output logic                                     wvalid,
    input  logic                                     wready,
    input  logic [ID_WIDTH_P-1:0]                    bid,
    input  logic [1:0]                               bresp,
    input  logic                                     bvalid,
    output logic                                     bready,
    // status
    output logic [NR_OF_PORTS_P-1:0]                 grant,
    output logic                                     wlast_error
);

    localparam int STRB_W = DATA_WIDTH_P/8;
    localparam int IDX_W  = (NR_OF_PORTS_P > 1) ? $clog2(NR_OF_PORTS_P) : 1;
    localparam logic [IDX_W:0] NP = (IDX_W+1)'(NR_OF_PORTS_P);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                   r_state, w_state_nxt;
    logic [NR_OF_PORTS_P-1:0] r_grant, w_grant_nxt;
    logic [IDX_W-1:0]         r_gidx, w_gidx_nxt;
    logic [IDX_W-1:0]         r_rr_ptr, w_rr_ptr_nxt;
    logic [7:0]               r_beat_cnt, w_beat_cnt_nxt;
    logic                     r_wlast_error, w_wlast_error_nxt;

    logic [ID_WIDTH_P-1:0]    w_awid_a    [NR_OF_PORTS_P];
    logic [ADDR_WIDTH_P-1:0]  w_awaddr_a  [NR_OF_PORTS_P];
    logic [7:0]               w_awlen_a   [NR_OF_PORTS_P];
    logic [2:0]               w_awsize_a  [NR_OF_PORTS_P];
    logic [1:0]               w_awburst_a [NR_OF_PORTS_P];
    logic [DATA_WIDTH_P-1:0]  w_wdata_a   [NR_OF_PORTS_P];
    logic [STRB_W-1:0]        w_wstrb_a   [NR_OF_PORTS_P];

    logic             w_act, w_aw_hs, w_w_hs, w_b_hs, w_last_exp;
    logic             w_sel_found;
    logic [IDX_W-1:0] w_sel_idx;
    logic [IDX_W:0]   w_sum, w_inc;

    // Per-port slice views and response/ready demux; only the owner sees anything.
    for (genvar gp = 0; gp < NR_OF_PORTS_P; gp++) begin : g_port
        assign w_awid_a[gp]    = req_awid[gp*ID_WIDTH_P +: ID_WIDTH_P];
        assign w_awaddr_a[gp]  = req_awaddr[gp*ADDR_WIDTH_P +: ADDR_WIDTH_P];
        assign w_awlen_a[gp]   = req_awlen[gp*8 +: 8];
        assign w_awsize_a[gp]  = req_awsize[gp*3 +: 3];
        assign w_awburst_a[gp] = req_awburst[gp*2 +: 2];
        assign w_wdata_a[gp]   = req_wdata[gp*DATA_WIDTH_P +: DATA_WIDTH_P];
        assign w_wstrb_a[gp]   = req_wstrb[gp*STRB_W +: STRB_W];

        assign req_awready[gp] = r_grant[gp] && (r_state == ADDR) && awready;
        assign req_wready[gp]  = r_grant[gp] && (r_state == DATA) && wready;
        assign req_bvalid[gp]  = r_grant[gp] && (r_state == RESP) && bvalid;
        assign req_bid[gp*ID_WIDTH_P +: ID_WIDTH_P] =
            (r_grant[gp] && (r_state == RESP)) ? bid : '0;
        assign req_bresp[gp*2 +: 2] = (r_grant[gp] && (r_state == RESP)) ? bresp : 2'b00;
    end

    assign w_act   = |r_grant;
    assign awid    = w_act ? w_awid_a[r_gidx]    : '0;
    assign awaddr  = w_act ? w_awaddr_a[r_gidx]  : '0;
    assign awlen   = w_act ? w_awlen_a[r_gidx]   : '0;
    assign awsize  = w_act ? w_awsize_a[r_gidx]  : '0;
    assign awburst = w_act ? w_awburst_a[r_gidx] : '0;
    assign awvalid = w_act && (r_state == ADDR) && req_awvalid[r_gidx];
    assign wdata   = w_act ? w_wdata_a[r_gidx]   : '0;
    assign wstrb   = w_act ? w_wstrb_a[r_gidx]   : '0;
    assign wlast   = w_act && req_wlast[r_gidx];
    assign wvalid  = w_act && (r_state == DATA) && req_wvalid[r_gidx];
    assign bready  = w_act && (r_state == RESP) && req_bready[r_gidx];

    assign w_aw_hs    = awvalid && awready;
    assign w_w_hs     = wvalid && wready;
    assign w_b_hs     = bvalid && bready;
    assign w_last_exp = (r_beat_cnt == 8'd0);

    assign grant       = r_grant;
    assign wlast_error = r_wlast_error;

    // Round-robin search: first requester at or after r_rr_ptr, wrapping.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sum       = '0;
        for (int i = 0; i < NR_OF_PORTS_P; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
            if (w_sum >= NP)
                w_sum = w_sum - NP;
            if (!w_sel_found && req_awvalid[w_sum[IDX_W-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_gidx_nxt        = r_gidx;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_beat_cnt_nxt    = r_beat_cnt;
        w_wlast_error_nxt = 1'b0;
        w_inc             = {1'b0, w_sel_idx} + (IDX_W+1)'(1);
        case (r_state)
            IDLE: if (w_sel_found) begin
                w_grant_nxt            = '0;
                w_grant_nxt[w_sel_idx] = 1'b1;
                w_gidx_nxt             = w_sel_idx;
                w_rr_ptr_nxt           = (w_inc >= NP) ? '0 : w_inc[IDX_W-1:0];
                w_state_nxt            = ADDR;
            end
            ADDR: if (w_aw_hs) begin
                w_beat_cnt_nxt = awlen;
                w_state_nxt    = DATA;
            end
            DATA: if (w_w_hs) begin
                w_beat_cnt_nxt    = r_beat_cnt - 8'd1;
                // wlast must coincide exactly with the awlen-derived last beat
                w_wlast_error_nxt = wlast ^ w_last_exp;
                if (wlast || w_last_exp)
                    w_state_nxt = RESP;
            end
            RESP: if (w_b_hs) begin
                w_grant_nxt = '0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_gidx        <= '0;
            r_rr_ptr      <= '0;
            r_beat_cnt    <= '0;
            r_wlast_error <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_gidx        <= w_gidx_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_beat_cnt    <= w_beat_cnt_nxt;
            r_wlast_error <= w_wlast_error_nxt;
        end
    end

endmodule
